fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end. Generates sequential PCs, issues word requests to the instruction memory and buffers the returned words in order.
- Presents {pc, instr} to static_decoder's pc_i/data_i inputs through a valid/ready handshake.
- Handles redirects from branch/trap resolution by flushing the buffer and discarding stale in-flight responses.

Parameters:
- FIFO_DEPTH, 4: fetch-buffer entries; power of two, at least 2.
- MAX_OUTSTANDING, 2: maximum imem requests in flight; at most FIFO_DEPTH.
- BOOT_ADDR, 64'h8000_0000: PC loaded at reset; 4-byte aligned.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- redirect_valid_i  in  1  redirect the fetch PC this cycle
- redirect_pc_i  in  C::XLEN  new fetch PC
- imem_req_valid_o  out  1  request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  C::XLEN  word address; bits [1:0] always 0
- imem_rsp_valid_i  in  1  response valid; in request order; always accepted
- imem_rsp_data_i  in  32  instruction word
- imem_rsp_err_i  in  1  access fault on this response
- valid_o  out  1  decoder-side entry valid
- ready_i  in  1  decoder-side consumer ready
- pc_o  out  C::XLEN  PC of head entry; feeds static_decoder pc_i
- instr_o  out  32  instruction of head entry; feeds static_decoder data_i
- fault_o  out  1  head entry is a fetch fault; instr_o is 0

Behaviour:
Reset values:
- All outputs 0.
- pc register = BOOT_ADDR; FIFO empty; outstanding = 0; drop = 0; state RUN.

State machine:
- RUN: issue requests.
- HALT: entered when a fault entry is pushed. No requests are issued; the FIFO keeps draining. Only a redirect returns to RUN.

Request issue:
- imem_req_valid_o = RUN && !redirect_valid_i && outstanding < MAX_OUTSTANDING && (occupancy + outstanding) < FIFO_DEPTH.
- This credit rule guarantees every response has a free slot, so no backpressure on responses is needed.
- Once asserted, imem_req_valid_o and imem_req_addr_o stay stable until accepted. The only exception is a redirect, which may withdraw a pending request.
- On accept: pc += 4 and outstanding += 1. Wrap at 2^XLEN is silent.

Response handling:
- Each response decrements outstanding.
- If drop > 0: decrement drop and discard the response.
- Otherwise push {pc_of_request, data, err}. The PC is tracked by a response-PC register that advances by 4 per kept response.
- If err=1: push fault entry (instr 0) and enter HALT.

Redirect (highest priority):
- Flush the FIFO. The same-cycle pop and push are both ignored.
- drop = outstanding after this cycle's response decrement.
- pc = response-PC = redirect_pc_i; state = RUN.
- No request is issued in the redirect cycle.
- Misaligned redirect_pc_i (bits [1:0] != 0): push a single fault entry with pc_o = redirect_pc_i and enter HALT. No memory request is made.

Output handshake:
- valid_o = FIFO non-empty; pc_o/instr_o/fault_o come from the head entry.
- Pop on valid_o && ready_i.
- Outputs stay stable while valid_o && !ready_i.
- Simultaneous push and pop when full is impossible by construction; push and pop when non-full are both performed.

Latency:
- Response to valid_o: 1 cycle (registered FIFO).
- Reset to first request: 1 cycle after rst_ni deassertion.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty and a kept response arrives, the response drives valid_o/pc_o/instr_o/fault_o combinationally in the same cycle. If ready_i=1 it is consumed without being written to the FIFO; otherwise it is written normally.
- Undefined: always 1-cycle latency through the FIFO.
- Credit rule is identical in both cases.

Decomposition:
- fetch_pkg holds fetch_entry_t {pc, instr, fault}, the fetch state enum {RUN, HALT} and the BOOT_ADDR default.
- One sub-module: fetch_fifo. It is a generic circular FIFO of fetch_entry_t with push, pop, synchronous flush, full/empty and a count output, parameterised by depth, with wrap-around pointers plus an extra bit.
- Outstanding and drop counters and the PC logic stay in fetch_unit.

Test Plan:
- Reset, imem ready always, 1-cycle response, ready_i=1 -> requests to 0x80000000, 0x80000004, 0x80000008; valid_o with matching pc_o/instr_o; never more than 2 in flight.
- ready_i=0 for 20 cycles -> exactly 4 entries buffered plus 0 outstanding; imem_req_valid_o low; head pc_o stays 0x80000000 stable.
- Two requests outstanding, redirect to 0x80001000 -> both late responses dropped; next valid_o has pc_o = 0x80001000; no stale PC ever shown.
- Response with imem_rsp_err_i=1 for PC 0x80000008 -> fault_o=1, instr_o=0, pc_o=0x80000008; no further requests until redirect.
- Redirect to 0x80000002 -> single fault entry with pc_o=0x80000002; zero imem requests issued.
- With FETCH_BYPASS_EN, FIFO empty, ready_i=1 -> valid_o in the same cycle as imem_rsp_valid_i. Without the macro -> one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [XLEN-1:0] BOOT_ADDR_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetch entries; wrap-around pointers carry one extra bit
// so full and empty are distinguishable without a separate counter.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  output fetch_entry_t           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         push_en, pop_en;
  fetch_entry_t mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Flush wins over both operations in the same cycle.
  assign push_en = push_i && !full_o && !flush_i;
  assign pop_en  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem
// requests, in-order buffering and redirect flush. Optional macro: FETCH_BYPASS_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] BOOT_ADDR       = BOOT_ADDR_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            fault_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic            active_q;
  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d;
  logic            fault_pend_q, fault_pend_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  fetch_entry_t    fifo_head, push_entry, head;
  logic            push_valid, req_fire, rsp_keep, misaligned;
  logic [CW:0]     credit_sum;

  assign misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign credit_sum = {1'b0, fifo_count} + {1'b0, outst_q};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rsp_pc_d     = rsp_pc_q;
    drop_d       = drop_q;
    fault_pend_d = 1'b0;
    push_valid   = 1'b0;
    push_entry   = '0;

    imem_req_valid_o = active_q && (state_q == RUN) && !redirect_valid_i &&
                       !fifo_full && (outst_q < CW'(MAX_OUTSTANDING)) &&
                       (credit_sum < (CW+1)'(FIFO_DEPTH));
    req_fire = imem_req_valid_o && imem_req_ready_i;
    rsp_keep = imem_rsp_valid_i && (drop_q == '0);

    if (req_fire) pc_d = pc_q + XLEN'(4);
    outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
    if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;

    // A pending misaligned-redirect fault is pushed one cycle after the
    // redirect so the flush and the fault entry never collide.
    if (fault_pend_q) begin
      push_valid = 1'b1;
      push_entry = '{pc: pc_q, instr: '0, fault: 1'b1};
    end else if (rsp_keep) begin
      push_valid = 1'b1;
      push_entry = '{pc: rsp_pc_q,
                     instr: imem_rsp_err_i ? '0 : imem_rsp_data_i,
                     fault: imem_rsp_err_i};
      rsp_pc_d   = rsp_pc_q + XLEN'(4);
      if (imem_rsp_err_i) state_d = HALT;
    end

    if (redirect_valid_i) begin
      push_valid   = 1'b0;
      outst_d      = outst_q - CW'(imem_rsp_valid_i);
      drop_d       = outst_d;
      pc_d         = redirect_pc_i;
      rsp_pc_d     = redirect_pc_i;
      state_d      = misaligned ? HALT : RUN;
      fault_pend_d = misaligned;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      active_q     <= 1'b0;
      pc_q         <= BOOT_ADDR;
      rsp_pc_q     <= BOOT_ADDR;
      outst_q      <= '0;
      drop_q       <= '0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= 1'b1;
      pc_q         <= pc_d;
      rsp_pc_q     <= rsp_pc_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  assign imem_req_addr_o = active_q ? pc_q : '0;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  // An arriving response skips the empty buffer; it is stored only if the
  // consumer does not take it this cycle.
  assign bypass    = fifo_empty && push_valid && !fault_pend_q;
  assign valid_o   = !fifo_empty || bypass;
  assign head      = fifo_empty ? push_entry : fifo_head;
  assign fifo_push = push_valid && !(bypass && ready_i);
  assign fifo_pop  = !fifo_empty && ready_i;
`else
  assign valid_o   = !fifo_empty;
  assign head      = fifo_head;
  assign fifo_push = push_valid;
  assign fifo_pop  = valid_o && ready_i;
`endif

  assign pc_o    = valid_o ? head.pc    : '0;
  assign instr_o = valid_o ? head.instr : '0;
  assign fault_o = valid_o ? head.fault : 1'b0;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_valid_i),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory responder plus an
// expected-stream model (sequential PCs from the last redirect target).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] BOOT = 64'h8000_0000;
`ifdef FETCH_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        imem_rsp_err_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [63:0] pc_o;
  logic [31:0] instr_o;
  logic        fault_o;

  fetch_unit #(
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2),
    .BOOT_ADDR       (BOOT)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .pc_o             (pc_o),
    .instr_o          (instr_o),
    .fault_o          (fault_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // memory and model state
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0, last_due = 0, inflight = 0;
  int          lat_fix = 1;
  logic        lat_rand = 1'b0, rdy_always = 1'b1;
  logic [63:0] err_addr = '1;

  logic [63:0] exp_pc = BOOT, exp_req = BOOT, first_pc = '0;
  logic        mis = 1'b0, expect_none = 1'b0, seen_fault = 1'b0;
  int          reqs = 0, consumed = 0;
  logic        hold = 1'b0;
  logic [63:0] hold_pc;
  logic [31:0] hold_instr;
  logic        hold_fault;
  logic        lat_armed = 1'b0, lat_v0 = 1'b0, lat_v1 = 1'b0;
  int          lat_stage = 0;

  initial begin : env
    logic [63:0] a;
    logic        ef;
    int          due;
    forever begin
      @(posedge clk_i); #1;
      cyc++;
      imem_req_ready_i = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = mem_word(mq_addr[0]);
        imem_rsp_err_i   = (mq_addr[0] == err_addr);
      end else begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = $urandom;
        imem_rsp_err_i   = 1'($urandom_range(0, 1));
      end
      @(negedge clk_i);
      if (rst_ni) begin
        check("max_inflight", 64'(inflight <= 2), 64'd1);
        if (lat_stage == 1) begin
          lat_v1 = valid_o;
          lat_stage = 2;
        end
        if (imem_rsp_valid_i) begin
          if (lat_armed && !redirect_valid_i) begin
            lat_v0 = valid_o;
            lat_armed = 1'b0;
            lat_stage = 1;
          end
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
          inflight--;
        end
        if (redirect_valid_i) begin
          check("req_in_redirect", 64'(imem_req_valid_o), 64'd0);
          exp_pc = redirect_pc_i;
          exp_req = redirect_pc_i;
          mis = (redirect_pc_i[1:0] != 2'b00);
          expect_none = 1'b0;
          seen_fault = 1'b0;
          reqs = 0;
          consumed = 0;
          hold = 1'b0;
        end else begin
          if (hold) begin
            check("hold_valid", 64'(valid_o), 64'd1);
            check("hold_pc", pc_o, hold_pc);
            check("hold_instr", 64'(instr_o), 64'(hold_instr));
            check("hold_fault", 64'(fault_o), 64'(hold_fault));
          end
          if (valid_o && ready_i) begin
            if (consumed == 0) first_pc = pc_o;
            if (expect_none) begin
              check("extra_entry", 64'(valid_o), 64'd0);
            end else begin
              ef = mis || (exp_pc == err_addr);
              check("out_pc", pc_o, exp_pc);
              check("out_instr", 64'(instr_o), ef ? 64'd0 : 64'(mem_word(exp_pc)));
              check("out_fault", 64'(fault_o), 64'(ef));
              if (mis) expect_none = 1'b1;
              if (ef) seen_fault = 1'b1;
              exp_pc = exp_pc + 64'd4;
            end
            consumed++;
          end
          hold = valid_o && !ready_i;
          hold_pc = pc_o;
          hold_instr = instr_o;
          hold_fault = fault_o;
          if (imem_req_valid_o && imem_req_ready_i) begin
            check("req_addr", imem_req_addr_o, exp_req);
            check("req_while_halted", 64'(seen_fault || mis), 64'd0);
            a = imem_req_addr_o;
            due = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_fix);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(a);
            mq_due.push_back(due);
            inflight++;
            reqs++;
            exp_req = exp_req + 64'd4;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
  endtask

  task automatic do_redirect(input logic [63:0] target);
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = target;
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b0;
  endtask

  initial begin : main
    int r0;
    logic done;
    // reset: every output is zero while reset is held
    cycles(3);
    @(negedge clk_i);
    check("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    check("rst_req_addr", imem_req_addr_o, 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_pc", pc_o, 64'd0);
    check("rst_instr", 64'(instr_o), 64'd0);
    check("rst_fault", 64'(fault_o), 64'd0);
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("first_req_early", 64'(imem_req_valid_o), 64'd0);
    @(negedge clk_i);
    check("first_req", 64'(imem_req_valid_o), 64'd1);
    check("first_req_addr", imem_req_addr_o, BOOT);

    // consumer stalled: buffer fills to depth with nothing in flight
    cycles(20);
    @(negedge clk_i);
    check("stall_req_valid", 64'(imem_req_valid_o), 64'd0);
    check("stall_inflight", 64'(inflight), 64'd0);
    check("stall_buffered", 64'(reqs - consumed - inflight), 64'd4);
    check("stall_head_pc", pc_o, BOOT);
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    cycles(15);
    check("stream_progress", 64'(consumed > 8), 64'd1);

    // redirect with requests in flight: stale responses must vanish
    lat_fix = 3;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_i);
      if (inflight == 2) done = 1'b1;
    end
    check("two_inflight", 64'(done), 64'd1);
    do_redirect(64'h8000_1000);
    lat_fix = 1;
    cycles(20);
    check("redir_consumed", 64'(consumed > 0), 64'd1);
    check("redir_first_pc", first_pc, 64'h8000_1000);

    // access fault at 0x80000008 halts fetching
    err_addr = 64'h8000_0008;
    do_redirect(BOOT);
    cycles(20);
    r0 = reqs;
    cycles(10);
    @(negedge clk_i);
    check("fault_seen", 64'(seen_fault), 64'd1);
    check("halt_req_valid", 64'(imem_req_valid_o), 64'd0);
    check("halt_no_reqs", 64'(reqs), 64'(r0));

    // misaligned redirect: one fault entry, no requests
    do_redirect(64'h8000_0002);
    cycles(10);
    check("mis_entry_seen", 64'(expect_none), 64'd1);
    check("mis_no_reqs", 64'(reqs), 64'd0);

    // response-to-valid latency from an empty buffer
    err_addr = '1;
    do_redirect(64'h8000_3000);
    lat_armed = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_i);
      if (lat_stage == 2) done = 1'b1;
    end
    check("lat_probe_done", 64'(done), 64'd1);
    check("lat_same_cycle", 64'(lat_v0), 64'(BYPASS));
    check("lat_by_next", 64'(lat_v0 || lat_v1), 64'd1);

    // random traffic with occasional redirects and faults
    rdy_always = 1'b0;
    lat_rand = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk_i); #1;
      ready_i = ($urandom_range(0, 3) != 0);
      if (!redirect_valid_i && $urandom_range(0, 39) == 0) begin
        redirect_valid_i = 1'b1;
        redirect_pc_i = BOOT + (64'($urandom_range(0, 255)) << 2);
        if ($urandom_range(0, 7) == 0) redirect_pc_i = redirect_pc_i + 64'd2;
        err_addr = ($urandom_range(0, 2) == 0) ?
                   redirect_pc_i + (64'($urandom_range(0, 6)) << 2) : '1;
      end else begin
        redirect_valid_i = 1'b0;
      end
    end
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b0;
    ready_i = 1'b1;
    cycles(20);
    check("final_inflight_bound", 64'(inflight <= 2), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
